// File: rtl/complex_mult_seq.sv
// Sequential complex multiplier: c = a * b over four cycles on one shared W x W
// signed multiplier, scaled by SHIFT and saturated back to the packed complex width.
module complex_mult_seq #(
    parameter int W     = 8,
    parameter int SHIFT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] c,
    output logic           ovf,
    output logic [2:0]     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE; out_valid is high only in DONE,
    // where c/ovf are held until out_ready is seen.

    localparam int AW = 2*W + 1;
    localparam logic signed [AW-1:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, RR, II, RI, IR, DONE} state_t;

    state_t                 state;
    logic signed [W-1:0]    ar, ai, br, bi;
    logic signed [W-1:0]    mul_x, mul_y;
    logic signed [2*W-1:0]  prod;
    logic signed [AW-1:0]   prod_ext, acc_re, acc_im, im_sum;
    logic        [W-1:0]    re_sat, im_sat;
    logic                   re_ovf, im_ovf;

    assign dbg_state = state;

    // Returns {saturated, value}; the shift floors toward -inf.
    function automatic logic [W:0] scale_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] r;
        r = v >>> SHIFT;
        if (r > SAT_MAX)      scale_sat = {1'b1, SAT_MAX[W-1:0]};
        else if (r < SAT_MIN) scale_sat = {1'b1, SAT_MIN[W-1:0]};
        else                  scale_sat = {1'b0, r[W-1:0]};
    endfunction

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            RR:      begin mul_x = ar; mul_y = br; end
            II:      begin mul_x = ai; mul_y = bi; end
            RI:      begin mul_x = ar; mul_y = bi; end
            IR:      begin mul_x = ai; mul_y = br; end
            default: ;
        endcase
    end

    assign prod     = mul_x * mul_y;
    assign prod_ext = {prod[2*W-1], prod};
    assign im_sum   = acc_im + prod_ext;

    always_comb begin
        {re_ovf, re_sat} = scale_sat(acc_re);
        {im_ovf, im_sat} = scale_sat(im_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
            ar        <= '0;
            ai        <= '0;
            br        <= '0;
            bi        <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ar       <= a[2*W-1:W];
                        ai       <= a[W-1:0];
                        br       <= b[2*W-1:W];
                        bi       <= b[W-1:0];
                        acc_re   <= '0;
                        acc_im   <= '0;
                        in_ready <= 1'b0;
                        state    <= RR;
                    end
                end
                RR: begin
                    acc_re <= acc_re + prod_ext;
                    state  <= II;
                end
                II: begin
                    acc_re <= acc_re - prod_ext;
                    state  <= RI;
                end
                RI: begin
                    acc_im <= acc_im + prod_ext;
                    state  <= IR;
                end
                IR: begin
                    acc_im    <= im_sum;
                    c         <= {re_sat, im_sat};
                    ovf       <= re_ovf | im_ovf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
